// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: round-robin sharing of a 16x16 register file between two
// requesters. The write port and the read port each have their own 1-bit
// priority pointer, so one write and one read can be granted in one cycle.
// Grants are combinational. Read data is registered into a one-cycle pulse
// on the requester's response channel.
module rf_port_arbiter #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req0_we,
  input  logic [AW-1:0]    req0_addr,
  input  logic [WIDTH-1:0] req0_wdata,
  input  logic             req1_valid,
  input  logic             req1_we,
  input  logic [AW-1:0]    req1_addr,
  input  logic [WIDTH-1:0] req1_wdata,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rf_en,
  output logic [AW-1:0]    rf_addr_w,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [AW-1:0]    rf_addr_r,
  input  logic [WIDTH-1:0] rf_rdata
);

  logic             wr_req0, wr_req1, rd_req0, rd_req1;
  logic             wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;
  logic             wr_pri_d, wr_pri_q;
  logic             rd_pri_d, rd_pri_q;
  logic             rsp0_valid_d, rsp0_valid_q;
  logic             rsp1_valid_d, rsp1_valid_q;
  logic [WIDTH-1:0] rsp0_data_d, rsp0_data_q;
  logic [WIDTH-1:0] rsp1_data_d, rsp1_data_q;

  // Split each requester's single request into write and read contenders.
  always_comb begin
    wr_req0 = req0_valid & req0_we;
    wr_req1 = req1_valid & req1_we;
    rd_req0 = req0_valid & ~req0_we;
    rd_req1 = req1_valid & ~req1_we;
  end

  // Write-port arbitration: a lone contender wins, otherwise the pointer decides.
  always_comb begin
    wr_gnt0 = 1'b0;
    wr_gnt1 = 1'b0;
    if (reset) begin
      wr_gnt0 = 1'b0;
      wr_gnt1 = 1'b0;
    end else if (wr_req0 && wr_req1) begin
      if (wr_pri_q) begin
        wr_gnt1 = 1'b1;
      end else begin
        wr_gnt0 = 1'b1;
      end
    end else begin
      wr_gnt0 = wr_req0;
      wr_gnt1 = wr_req1;
    end
  end

  // Read-port arbitration, independent of the write port.
  always_comb begin
    rd_gnt0 = 1'b0;
    rd_gnt1 = 1'b0;
    if (reset) begin
      rd_gnt0 = 1'b0;
      rd_gnt1 = 1'b0;
    end else if (rd_req0 && rd_req1) begin
      if (rd_pri_q) begin
        rd_gnt1 = 1'b1;
      end else begin
        rd_gnt0 = 1'b1;
      end
    end else begin
      rd_gnt0 = rd_req0;
      rd_gnt1 = rd_req1;
    end
  end

  // Ready and register-file pin muxing; idle pins are driven to zero.
  always_comb begin
    req0_ready = wr_gnt0 | rd_gnt0;
    req1_ready = wr_gnt1 | rd_gnt1;
    rf_en      = wr_gnt0 | wr_gnt1;
    rf_addr_w  = {AW{1'b0}};
    rf_wdata   = {WIDTH{1'b0}};
    rf_addr_r  = {AW{1'b0}};
    if (wr_gnt0) begin
      rf_addr_w = req0_addr;
      rf_wdata  = req0_wdata;
    end else if (wr_gnt1) begin
      rf_addr_w = req1_addr;
      rf_wdata  = req1_wdata;
    end else begin
      rf_addr_w = {AW{1'b0}};
      rf_wdata  = {WIDTH{1'b0}};
    end
    if (rd_gnt0) begin
      rf_addr_r = req0_addr;
    end else if (rd_gnt1) begin
      rf_addr_r = req1_addr;
    end else begin
      rf_addr_r = {AW{1'b0}};
    end
  end

  // Next-state: pointers flip away from the winner only on a grant; read
  // data is captured for the granted requester and otherwise held.
  always_comb begin
    wr_pri_d = wr_pri_q;
    rd_pri_d = rd_pri_q;
    if (wr_gnt0) begin
      wr_pri_d = 1'b1;
    end else if (wr_gnt1) begin
      wr_pri_d = 1'b0;
    end else begin
      wr_pri_d = wr_pri_q;
    end
    if (rd_gnt0) begin
      rd_pri_d = 1'b1;
    end else if (rd_gnt1) begin
      rd_pri_d = 1'b0;
    end else begin
      rd_pri_d = rd_pri_q;
    end
    rsp0_valid_d = rd_gnt0;
    rsp1_valid_d = rd_gnt1;
    if (rd_gnt0) begin
      rsp0_data_d = rf_rdata;
    end else begin
      rsp0_data_d = rsp0_data_q;
    end
    if (rd_gnt1) begin
      rsp1_data_d = rf_rdata;
    end else begin
      rsp1_data_d = rsp1_data_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_pri_q     <= 1'b0;
      rd_pri_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= {WIDTH{1'b0}};
      rsp1_data_q  <= {WIDTH{1'b0}};
    end else begin
      wr_pri_q     <= wr_pri_d;
      rd_pri_q     <= rd_pri_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  // Response outputs; a pulse that lands in a reset cycle is suppressed so a
  // read granted just before reset never returns.
  always_comb begin
    rsp0_valid = rsp0_valid_q & ~reset;
    rsp1_valid = rsp1_valid_q & ~reset;
    rsp0_data  = rsp0_data_q;
    rsp1_data  = rsp1_data_q;
  end

endmodule

// File: doc/rf_port_arbiter.md
# rf_port_arbiter

Round-robin arbiter sharing the 16-entry x 16-bit register file between two requesters (0 and 1). The write port and the read port are arbitrated independently, so one write and one read can be granted in the same cycle. Each requester uses a valid/ready request channel and a registered, single-cycle read-response pulse. The block sits between the datapath requesters and the register file's EN/address_W/RF_Data/address_R/RF_out pins.

## Interface
- WIDTH, 16, data width; must match the register file
- AW, 4, address width (16 entries)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present; held stable until its ready is seen
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  AW  target entry
- req0_wdata / req1_wdata  in  WIDTH  write data; ignored for reads
- req0_ready / req1_ready  out  1  request granted this cycle (combinational)
- rsp0_valid / rsp1_valid  out  1  one-cycle pulse carrying read data
- rsp0_data / rsp1_data  out  WIDTH  read data; valid only while its rsp valid is high
- rf_en  out  1  register-file write enable
- rf_addr_w  out  AW  register-file write address
- rf_wdata  out  WIDTH  register-file write data
- rf_addr_r  out  AW  register-file read address
- rf_rdata  in  WIDTH  register-file combinational read data

## Operation
- Write contenders: requesters with valid=1, we=1. Read contenders: requesters with valid=1, we=0.
- Write and read arbitration are independent. Each has its own 1-bit priority pointer: wr_pri and rd_pri.
- Single contender on a port: granted immediately.
- Two contenders on a port: the requester named by that port's pointer wins. The loser keeps valid asserted and wins next cycle.
- After any grant on a port, that port's pointer moves to the other requester. Worst-case wait is 1 cycle.
- Write grant to requester k:
  - req_k_ready = 1, rf_en = 1
  - rf_addr_w = req_k_addr, rf_wdata = req_k_wdata
  - the register file captures the data at the end of the cycle.
- Read grant to requester k:
  - req_k_ready = 1, rf_addr_r = req_k_addr
  - rf_rdata is registered into rsp_k_data and rsp_k_valid = 1 on the next cycle.
- Idle values:
  - no write grant: rf_en = 0; rf_addr_w and rf_wdata are 0.
  - no read grant: rf_addr_r is 0.
- Read and write to the same address in the same cycle: the read returns the pre-write value (read-before-write). There is no bypass.
- A requester holds at most one request, so at most one grant per requester per cycle.
- Responses have no backpressure. The requester must sample rsp data during the pulse.
- rsp_k_data holds its last value when rsp_k_valid = 0.

## Timing
- Reset values:
  - wr_pri = rd_pri = requester 0
  - rsp0_valid = rsp1_valid = 0
  - rsp0_data = rsp1_data = 0
- While reset = 1: req0_ready = req1_ready = 0 and rf_en = 0, regardless of requests.
- Ready is combinational from valid/we and the pointers: 0-cycle grant latency.
- Write latency: data is visible in the register file in the cycle after the grant.
- Read latency: rsp_valid is asserted exactly 1 cycle after the ready cycle.
- Back-to-back reads from one requester give back-to-back rsp pulses.
- Reset asserted in the cycle after a read grant: the pending response is dropped; rsp_valid stays 0.
- Pointer update happens only on a grant. A contender that withdraws does not move the pointer.

## Test plan
- Reset, then both requesters idle: ready0/1 = 0, rf_en = 0, rsp_valid0/1 = 0 for 5 cycles.
- req0 writes addr 3 = 0xBEEF, then reads addr 3: ready0 in each request cycle; rsp0_valid pulses 1 cycle after the read grant with rsp0_data = 0xBEEF.
- Both write continuously (req0 addr 1 = 0x1111, req1 addr 2 = 0x2222) from reset: grants go 0,1,0,1…; neither waits more than 1 cycle.
- req0 writes addr 5 = 0x0A0A while req1 reads addr 5 (old value 0x1234), same cycle: both ready; rsp1_data = 0x1234; a later read returns 0x0A0A.
- Both read (addr 7 = 0x0007, addr 8 = 0x0008) with rd_pri = 1: req1 is granted first, then req0; responses appear on consecutive cycles, each on the correct rsp channel.
- Reset asserted in the cycle after a read grant: no rsp pulse; pointers return to requester 0.
